// File: rtl/clock_pkg.sv
// Shared definitions for the clock_counter block: mode encodings and field limits.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  // Largest value a seconds or minutes field reaches before wrapping.
  localparam int unsigned MIN_SEC_MAX = 59;
  // Largest value the hours field reaches before wrapping.
  localparam int unsigned HOUR_MAX    = 23;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MODULUS-1 back to 00.
// carry flags the increment that causes the wrap so the next field can advance on the same edge.
module bcd_mod_counter #(
  parameter int unsigned MODULUS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  localparam logic [3:0] TOP_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] TOP_ONES = 4'((MODULUS - 1) % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_top;

  assign at_top = (tens_q == TOP_TENS) && (ones_q == TOP_ONES);
  assign carry  = inc && at_top;
  assign tens   = tens_q;
  assign ones   = ones_q;

  // Next value: clear wins over increment; the top value wraps, a 9 rolls into the tens digit
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (at_top) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/clock_counter.sv
// 24-hour HH:MM:SS clock with a one-second prescaler and a three-state set mode.
// Digits are BCD and come straight from the field registers.
module clock_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       sec_tick
);

  localparam int unsigned   PW      = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  mode_e         mode_q;
  logic [PW-1:0] pre_q;
  logic          tick_q;

  logic run_adv;
  logic tick;
  logic set_exit;
  logic sec_carry;
  logic min_carry;
  logic hr_carry_unused;
  logic min_inc;
  logic hr_inc;

  // A mode press freezes the prescaler on that same edge, so no tick can slip into a SET mode.
  assign run_adv  = (mode_q == RUN) && !btn_mode;
  assign tick     = run_adv && (pre_q == PRE_MAX);
  assign set_exit = (mode_q == SET_MIN) && btn_mode;

  // btn_mode has priority over btn_inc on the same cycle.
  assign min_inc = (tick && sec_carry) || ((mode_q == SET_MIN) && btn_inc && !btn_mode);
  assign hr_inc  = (tick && sec_carry && min_carry) ||
                   ((mode_q == SET_HOUR) && btn_inc && !btn_mode);

  assign mode     = mode_q;
  assign sec_tick = tick_q;

  // Prescaler: counts only in RUN, restarts from 0 when leaving SET_MIN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (set_exit) begin
      pre_q <= '0;
    end else if (run_adv) begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
    end
  end

  // sec_tick is high for the cycle after the edge that advanced seconds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
    end
  end

  // Mode FSM: RUN -> SET_HOUR -> SET_MIN -> RUN on each btn_mode pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= RUN;
    end else if (btn_mode) begin
      unique case (mode_q)
        RUN:      mode_q <= SET_HOUR;
        SET_HOUR: mode_q <= SET_MIN;
        default:  mode_q <= RUN;
      endcase
    end
  end

  bcd_mod_counter #(
    .MODULUS(MIN_SEC_MAX + 1)
  ) u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (tick),
    .clr  (set_exit),
    .tens (sec_tens),
    .ones (sec_ones),
    .carry(sec_carry)
  );

  bcd_mod_counter #(
    .MODULUS(MIN_SEC_MAX + 1)
  ) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (min_inc),
    .clr  (1'b0),
    .tens (min_tens),
    .ones (min_ones),
    .carry(min_carry)
  );

  bcd_mod_counter #(
    .MODULUS(HOUR_MAX + 1)
  ) u_hr (
    .clk  (clk),
    .rst  (rst),
    .inc  (hr_inc),
    .clr  (1'b0),
    .tens (hr_tens),
    .ones (hr_ones),
    .carry(hr_carry_unused)
  );

endmodule

// File: tb/tb_clock_counter.sv
// Scoreboard bench for clock_counter with CLK_DIV = 4.
// Stimulus pushes expected snapshots and tick cycles; one monitor pops and compares.
module tb_clock_counter;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] mode;
  logic       sec_tick;

  int cyc      = 0;
  int n_checks = 0;
  int n_fails  = 0;
  bit tick_watch = 1'b0;
  bit async_req  = 1'b0;
  bit final_req  = 1'b0;
  event ev;

  typedef struct packed {
    int          at;
    bit          is_async;
    logic [23:0] t;
    logic [1:0]  md;
    logic        tk;
  } snap_t;

  snap_t snap_q[$];
  string name_q[$];
  int    tick_q[$];

  clock_counter #(
    .CLK_DIV(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .hr_tens (hr_tens),
    .hr_ones (hr_ones),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .mode    (mode),
    .sec_tick(sec_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic push_snap(input string nm, input int at, input bit as, input int h,
                           input int m, input int s, input logic [1:0] md, input logic tk);
    snap_t e;
    e.at       = at;
    e.is_async = as;
    e.t        = hms(h, m, s);
    e.md       = md;
    e.tk       = tk;
    snap_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_snap();
    snap_t       s;
    string       nm;
    logic [23:0] act;
    s   = snap_q.pop_front();
    nm  = name_q.pop_front();
    act = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
    n_checks += 3;
    if (act !== s.t) begin
      n_fails++;
      $display("FAIL %s time: got %h expected %h (cycle %0d)", nm, act, s.t, cyc);
    end
    if (mode !== s.md) begin
      n_fails++;
      $display("FAIL %s mode: got %0d expected %0d (cycle %0d)", nm, mode, s.md, cyc);
    end
    if (sec_tick !== s.tk) begin
      n_fails++;
      $display("FAIL %s sec_tick: got %b expected %b (cycle %0d)", nm, sec_tick, s.tk, cyc);
    end
  endtask

  // Monitor: all comparisons and counter updates happen in this one process
  initial begin
    int    t;
    snap_t s;
    string nm;
    forever begin
      @(negedge clk or ev);
      if (final_req) begin
        while (tick_q.size() > 0) begin
          t = tick_q.pop_front();
          n_checks++;
          n_fails++;
          $display("FAIL missing_tick: got none, expected sec_tick at cycle %0d", t);
        end
        while (snap_q.size() > 0) begin
          s  = snap_q.pop_front();
          nm = name_q.pop_front();
          n_checks++;
          n_fails++;
          $display("FAIL %s: got no sample, expected one at cycle %0d", nm, s.at);
        end
      end else if (async_req) begin
        if (snap_q.size() > 0 && snap_q[0].is_async) check_snap();
      end else begin
        while (snap_q.size() > 0 && !snap_q[0].is_async && snap_q[0].at <= cyc) check_snap();
        if (tick_watch && sec_tick === 1'b1) begin
          n_checks++;
          if (tick_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_tick: got sec_tick at cycle %0d, expected none", cyc);
          end else begin
            t = tick_q.pop_front();
            if (t != cyc) begin
              n_fails++;
              $display("FAIL tick_cycle: got sec_tick at cycle %0d, expected cycle %0d", cyc, t);
            end
          end
        end
      end
    end
  end

  // Apply buttons for n edges; called and returns 1 time unit after a rising edge
  task automatic drive(input logic m, input logic i, input int n);
    btn_mode = m;
    btn_inc  = i;
    repeat (n) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic async_check();
    async_req = 1'b1;
    ->ev;
    #1;
    async_req = 1'b0;
  endtask

  initial begin
    int c0;
    int e;
    int f;
    int r;
    rst      = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #1 rst = 1'b1;
    #1;
    push_snap("reset_before_clk", 0, 1'b1, 0, 0, 0, 2'd0, 1'b0);
    async_check();
    step(2);

    // Release reset; btn_inc in RUN is ignored; two ticks four cycles apart
    rst = 1'b0;
    c0  = cyc;
    tick_watch = 1'b1;
    tick_q.push_back(c0 + 4);
    tick_q.push_back(c0 + 8);
    push_snap("run_inc_ignored", c0 + 3, 1'b0, 0, 0, 0, 2'd0, 1'b0);
    push_snap("first_tick", c0 + 4, 1'b0, 0, 0, 1, 2'd0, 1'b1);
    push_snap("second_tick", c0 + 8, 1'b0, 0, 0, 2, 2'd0, 1'b1);
    drive(1'b0, 1'b1, 2);
    step(6);

    // Set hours: 25 increments from 00 wrap to 01; held pulses count per cycle
    drive(1'b1, 1'b0, 1);
    push_snap("enter_set_hour", cyc, 1'b0, 0, 0, 2, 2'd1, 1'b0);
    drive(1'b0, 1'b1, 10);
    for (int k = 0; k < 15; k++) drive(1'b0, 1'b1, 1);
    push_snap("hour_mod24", cyc, 1'b0, 1, 0, 2, 2'd1, 1'b0);
    drive(1'b1, 1'b1, 1);
    push_snap("mode_beats_inc", cyc, 1'b0, 1, 0, 2, 2'd2, 1'b0);

    // Minutes wrap 59 -> 00 with no carry into hours
    drive(1'b0, 1'b1, 59);
    push_snap("min_at_59", cyc, 1'b0, 1, 59, 2, 2'd2, 1'b0);
    drive(1'b0, 1'b1, 1);
    push_snap("min_wrap_no_carry", cyc, 1'b0, 1, 0, 2, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1);
    e = cyc;
    push_snap("exit_set_clears_sec", e, 1'b0, 1, 0, 0, 2'd0, 1'b0);
    push_snap("no_tick_before_4", e + 3, 1'b0, 1, 0, 0, 2'd0, 1'b0);
    push_snap("tick_after_exit", e + 4, 1'b0, 1, 0, 1, 2'd0, 1'b1);
    tick_q.push_back(e + 4);
    step(4);

    // Preload 23:59, run to 23:59:59, then one tick rolls everything over
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 22);
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 59);
    push_snap("preload_2359", cyc, 1'b0, 23, 59, 1, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1);
    e = cyc;
    tick_watch = 1'b0;
    step(236);
    push_snap("at_235959", cyc, 1'b0, 23, 59, 59, 2'd0, 1'b1);
    step(1);
    tick_watch = 1'b1;
    tick_q.push_back(e + 240);
    push_snap("hold_235959", e + 239, 1'b0, 23, 59, 59, 2'd0, 1'b0);
    push_snap("rollover_000000", e + 240, 1'b0, 0, 0, 0, 2'd0, 1'b1);
    step(3);

    // Bring the clock to 12:34:56 and reset it mid-count
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 12);
    drive(1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 34);
    push_snap("preload_1234", cyc, 1'b0, 12, 34, 0, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1);
    f = cyc;
    tick_watch = 1'b0;
    step(225);
    push_snap("at_123456", cyc, 1'b0, 12, 34, 56, 2'd0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    push_snap("reset_mid_count", 0, 1'b1, 0, 0, 0, 2'd0, 1'b0);
    async_check();
    step(2);
    rst = 1'b0;
    r   = cyc;
    tick_watch = 1'b1;
    tick_q.push_back(r + 4);
    tick_q.push_back(r + 8);
    push_snap("post_reset_tick1", r + 4, 1'b0, 0, 0, 1, 2'd0, 1'b1);
    push_snap("post_reset_tick2", r + 8, 1'b0, 0, 0, 2, 2'd0, 1'b1);
    step(10);

    final_req = 1'b1;
    ->ev;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
